// File: rtl/pet_prg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pet_prg_loader
// Purpose  : Loads a PRG byte stream (2-byte little-endian load address
//            followed by payload) into PET main RAM through the pet2001hw
//            DMA port. The CPU is held via cpu_hold for the whole load.
//            Payload writes are confined below RAM_TOP. When the image
//            loads at BASIC_START, the BASIC end-of-program pointers
//            (VARTAB/ARYTAB/STREND) are patched afterwards.
// Ports    : clk, reset_n (async, active low)
//            dl_start/dl_valid/dl_data/dl_last -> byte stream in
//            dl_ready                          -> byte accepted this cycle
//            dma_addr/dma_din/dma_we           -> RAM write port
//            cpu_hold (to clk_stop), busy, done (pulse), error (sticky)
// Options  : PRG_AUTORUN_EN - after the pointer patch, stuff "RUN<CR>"
//            into the keyboard buffer and set its count to 4.
// Revision : 1.0 - initial release
// ============================================================================
module pet_prg_loader #(
   parameter logic [15:0] RAM_TOP     = 16'h8000,
   parameter logic [15:0] BASIC_START = 16'h0401,
   parameter logic [15:0] PTR_BASE    = 16'h002A,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_start,
   input  logic        dl_valid,
   input  logic [7:0]  dl_data,
   input  logic        dl_last,
   output logic        dl_ready,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_din,
   output logic        dma_we,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HOLD   = 3'd1,
      HDR_LO = 3'd2,
      HDR_HI = 3'd3,
      DATA   = 3'd4,
      PTR    = 3'd5,
`ifdef PRG_AUTORUN_EN
      RUN    = 3'd7,
`endif
      FIN    = 3'd6
   } state_t;

   state_t      state;
   logic [7:0]  hold_cnt;
   logic [7:0]  addr_lo;
   logic [15:0] load_addr;
   logic [15:0] ptr;        // next payload address; equals E once payload ends
   logic [2:0]  step;       // index within the PTR / RUN write bursts

   logic        accept;
   logic        data_ok;
   logic [15:0] hdr_addr;
   logic [15:0] ptr_wr_addr;

   // dl_ready is a pure decode of the state register, so it is glitch-free
   // and already valid for the whole cycle before the sampling edge.
   assign dl_ready    = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
   assign accept      = dl_valid & dl_ready;
   assign data_ok     = (ptr < RAM_TOP);
   assign hdr_addr    = {dl_data, addr_lo};
   assign ptr_wr_addr = PTR_BASE + 16'(step);

`ifdef PRG_AUTORUN_EN
   logic [15:0] run_addr;
   logic [7:0]  run_data;

   // Keyboard buffer "RUN<CR>" at 026F..0272, then buffer count at 009E.
   always_comb begin
      run_addr = 16'h026F + 16'(step);
      run_data = 8'h00;
      case (step)
         3'd0:    run_data = 8'h52;
         3'd1:    run_data = 8'h55;
         3'd2:    run_data = 8'h4E;
         3'd3:    run_data = 8'h0D;
         default: begin
            run_addr = 16'h009E;
            run_data = 8'h04;
         end
      endcase
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         hold_cnt  <= 8'd0;
         addr_lo   <= 8'd0;
         load_addr <= 16'd0;
         ptr       <= 16'd0;
         step      <= 3'd0;
         dma_addr  <= 16'd0;
         dma_din   <= 8'd0;
         dma_we    <= 1'b0;
         cpu_hold  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         dma_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            // FIN already has busy low, so a start there is honoured too.
            IDLE, FIN: begin
               if (dl_start) begin
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  error    <= 1'b0;
                  hold_cnt <= 8'(HOLD_CYCLES);
                  state    <= HOLD;
               end else begin
                  state <= IDLE;
               end
            end

            HOLD: begin
               if (hold_cnt <= 8'd1) begin
                  state <= HDR_LO;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end

            HDR_LO: begin
               if (accept) begin
                  addr_lo <= dl_data;
                  if (dl_last) begin
                     error    <= 1'b1;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     state    <= FIN;
                  end else begin
                     state <= HDR_HI;
                  end
               end
            end

            HDR_HI: begin
               if (accept) begin
                  load_addr <= hdr_addr;
                  ptr       <= hdr_addr;
                  step      <= 3'd0;
                  // Header-only image: nothing to write, but still patch
                  // the pointers (E = load address) at BASIC_START.
                  if (!dl_last) begin
                     state <= DATA;
                  end else if (hdr_addr == BASIC_START) begin
                     state <= PTR;
                  end else begin
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     state    <= FIN;
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  ptr <= ptr + 16'd1;
                  if (data_ok) begin
                     dma_addr <= ptr;
                     dma_din  <= dl_data;
                     dma_we   <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
                  if (dl_last) begin
                     // The current byte's range check joins the sticky flag.
                     if ((load_addr == BASIC_START) && !error && data_ok) begin
                        step  <= 3'd0;
                        state <= PTR;
                     end else begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        state    <= FIN;
                     end
                  end
               end
            end

            PTR: begin
               dma_addr <= ptr_wr_addr;
               dma_din  <= step[0] ? ptr[15:8] : ptr[7:0];
               dma_we   <= (ptr_wr_addr < RAM_TOP);
               if (step == 3'd5) begin
                  step <= 3'd0;
`ifdef PRG_AUTORUN_EN
                  state <= RUN;
`else
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  state    <= FIN;
`endif
               end else begin
                  step <= step + 3'd1;
               end
            end

`ifdef PRG_AUTORUN_EN
            RUN: begin
               dma_addr <= run_addr;
               dma_din  <= run_data;
               dma_we   <= (run_addr < RAM_TOP);
               if (step == 3'd4) begin
                  step     <= 3'd0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  state    <= FIN;
               end else begin
                  step <= step + 3'd1;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pet_prg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pet_prg_loader
// Purpose  : Scoreboard bench for pet_prg_loader. Each load pushes the RAM
//            writes and the final error flag it should produce; a monitor
//            pops them as the DUT writes and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pet_prg_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        dl_start;
   logic        dl_valid;
   logic [7:0]  dl_data;
   logic        dl_last;
   logic        dl_ready;
   logic [15:0] dma_addr;
   logic [7:0]  dma_din;
   logic        dma_we;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   always #5 clk = ~clk;

   pet_prg_loader dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .dl_start (dl_start),
      .dl_valid (dl_valid),
      .dl_data  (dl_data),
      .dl_last  (dl_last),
      .dl_ready (dl_ready),
      .dma_addr (dma_addr),
      .dma_din  (dma_din),
      .dma_we   (dma_we),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  wr_q[$];
   bit   done_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   gaps_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   // ---------------- reference model ----------------
   task automatic expect_load(input logic [15:0] l, input logic [7:0] d[$]);
      logic [15:0] a;
      logic [15:0] e;
      bit          err;
      err = 1'b0;
      for (int i = 0; i < d.size(); i++) begin
         a = l + 16'(i);
         if (a < 16'h8000) wr_q.push_back('{addr: a, data: d[i]});
         else              err = 1'b1;
      end
      if (!err && l == 16'h0401) begin
         e = l + 16'(d.size());
         for (int k = 0; k < 6; k++)
            wr_q.push_back('{addr: 16'h002A + 16'(k), data: (k % 2 == 1) ? e[15:8] : e[7:0]});
`ifdef PRG_AUTORUN_EN
         wr_q.push_back('{addr: 16'h026F, data: 8'h52});
         wr_q.push_back('{addr: 16'h0270, data: 8'h55});
         wr_q.push_back('{addr: 16'h0271, data: 8'h4E});
         wr_q.push_back('{addr: 16'h0272, data: 8'h0D});
         wr_q.push_back('{addr: 16'h009E, data: 8'h04});
`endif
      end
      done_q.push_back(err);
   endtask

   // ---------------- monitor ----------------
   wr_t mon_e;
   bit  mon_err;
   always @(negedge clk) begin
      if (reset_n && dma_we) begin
         check("rom_guard", 32'(dma_addr >= 16'h8000), 32'd0);
         if (wr_q.size() == 0) fail_now("unexpected_write");
         else begin
            mon_e = wr_q.pop_front();
            check("dma_write", 32'({dma_addr, dma_din}), 32'({mon_e.addr, mon_e.data}));
         end
      end
      if (reset_n && done) begin
         if (done_q.size() == 0) fail_now("unexpected_done");
         else begin
            mon_err = done_q.pop_front();
            check("done_error", 32'(error), 32'(mon_err));
            check("done_release", 32'({busy, cpu_hold}), 32'd0);
            check("writes_drained", 32'(wr_q.size()), 32'd0);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic start_load(input bit valid_early, input logic [7:0] first);
      int  cnt;
      bit  hold_ok;
      @(negedge clk);
      dl_start = 1'b1;
      if (valid_early) begin
         dl_valid = 1'b1;
         dl_data  = first;
         dl_last  = 1'b0;
      end
      @(negedge clk);
      dl_start = 1'b0;
      check("start_flags", 32'({busy, cpu_hold, error}), 32'b110);
      cnt = 0;
      hold_ok = 1'b1;
      while (!dl_ready && cnt < 50) begin
         if (!cpu_hold) hold_ok = 1'b0;
         cnt++;
         @(negedge clk);
      end
      check("hold_cycles", 32'(cnt), 32'd4);
      check("hold_cpu", 32'(hold_ok), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last, input bit poke);
      int budget;
      if (gaps_en && $urandom_range(0, 2) == 0) begin
         dl_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      dl_valid = 1'b1;
      dl_data  = b;
      dl_last  = last;
      dl_start = poke;
      budget = 0;
      while (!dl_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 100) fail_now("ready_timeout");
      @(negedge clk);
      dl_valid = 1'b0;
      dl_last  = 1'b0;
      dl_start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         fail_now("done_timeout");
         done_q.delete();
         wr_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic send_load(input logic [15:0] l, input logic [7:0] d[$], input bit valid_early);
      expect_load(l, d);
      start_load(valid_early, l[7:0]);
      send_byte(l[7:0], 1'b0, 1'b0);
      send_byte(l[15:8], d.size() == 0, 1'b0);
      for (int i = 0; i < d.size(); i++)
         send_byte(d[i], i == d.size() - 1, i == 1);
      wait_done();
   endtask

   // ---------------- stimulus ----------------
   logic [7:0]  pl[$];
   logic [15:0] la;

   initial begin
      reset_n  = 1'b0;
      dl_start = 1'b0;
      dl_valid = 1'b0;
      dl_data  = 8'h00;
      dl_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({dl_ready, dma_addr, dma_din, dma_we, cpu_hold, busy, done, error}), 32'd0);
      reset_n = 1'b1;

      // Stream bytes without a start: nothing may be accepted.
      dl_valid = 1'b1;
      dl_data  = 8'h55;
      repeat (5) @(negedge clk);
      check("idle_ready", 32'({dl_ready, busy}), 32'd0);
      dl_valid = 1'b0;

      // Basic load at BASIC_START.
      pl.delete(); pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
      send_load(16'h0401, pl, 1'b0);

      // Crosses RAM_TOP: only 7FFE/7FFF written, error set.
      pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33); pl.push_back(8'h44);
      send_load(16'h7FFE, pl, 1'b0);

      // dl_valid held high from dl_start through HOLD.
      pl.delete(); pl.push_back(8'h5A); pl.push_back(8'hA5);
      send_load(16'h1000, pl, 1'b1);

      // Truncated header: last on the low address byte.
      done_q.push_back(1'b1);
      start_load(1'b0, 8'h00);
      send_byte(8'h01, 1'b1, 1'b0);
      wait_done();
      check("trunc_idle", 32'({busy, cpu_hold, error}), 32'b001);

      // Next load clears the error.
      pl.delete(); pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
      send_load(16'h0401, pl, 1'b0);

      // Reset after two data bytes.
      wr_q.push_back('{addr: 16'h0401, data: 8'h12});
      wr_q.push_back('{addr: 16'h0402, data: 8'h34});
      start_load(1'b0, 8'h00);
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h04, 1'b0, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'h34, 1'b0, 1'b0);
      @(negedge clk);
      check("pre_reset_writes", 32'(wr_q.size()), 32'd0);
      reset_n = 1'b0;
      #1;
      check("midload_reset", 32'({dl_ready, dma_addr, dma_din, dma_we, cpu_hold, busy, done, error}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_no_we", 32'(dma_we), 32'd0);
      end
      reset_n = 1'b1;
      pl.delete(); pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
      send_load(16'h0401, pl, 1'b0);

      // Randomised loads with gaps.
      gaps_en = 1'b1;
      for (int t = 0; t < 10; t++) begin
         case ($urandom_range(0, 2))
            0:       la = 16'h0401;
            1:       la = 16'(16'h0400 + 16'($urandom_range(0, 16'h7000)));
            default: la = 16'(16'h7FF0 + 16'($urandom_range(0, 15)));
         endcase
         pl.delete();
         for (int i = 0; i < int'($urandom_range(1, 12)); i++) pl.push_back(8'($urandom));
         send_load(la, pl, $urandom_range(0, 1) == 1);
      end
      gaps_en = 1'b0;

      check("final_queues", 32'(wr_q.size() + done_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
